fpu_out_arb: RTL

Parametrised FPU output arbiter that collects results from NPIPE execution pipes and issues one registered request per cycle to the CPX interface. It adds per-pipe result queues, honours CPX backpressure, and uses strict priority for the top pipe with round-robin among the rest. It sits between the FPU pipe output stages (add/mul/div and future pipes) and the FPU-to-CPX request/data path, and supersedes the fixed 3-pipe, no-stall output control.

---
 rtl/fpu_out_arb_pkg.sv | 27 ++
 rtl/fpu_out_arb_q.sv | 86 ++++++++
 rtl/fpu_out_arb.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_out_arb_pkg.sv
// fpu_out_arb_pkg
//   Shared definitions for the FPU output arbiter: how a result ID splits
//   into CPX request and thread fields, default sizing, and a one-hot to
//   index helper used when the arbitration winner is encoded.
package fpu_out_arb_pkg;

  // The low THR_W bits of a result ID carry the thread; the rest is the
  // CPX request field.
  localparam int THR_W          = 2;

  localparam int NPIPE_DEF      = 3;
  localparam int ID_W_DEF       = 10;
  localparam int QDEPTH_DEF     = 2;
  localparam int STARVE_MAX_DEF = 15;

  // Index of the set bit of a one-hot vector (zero-extended to 32 bits).
  // Returns 0 for an all-zero input.
  function automatic int unsigned oh_to_idx(input logic [31:0] oh);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) idx = idx | unsigned'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/fpu_out_arb_q.sv
// fpu_out_arb_q
//   Result queue for one FPU pipe. A push to a full queue is accepted only
//   when a pop happens in the same cycle; otherwise it is dropped and
//   drop_o is raised for that cycle. The full flag is registered.
//
// Ports
//   clk_i    clock
//   rst_ni   asynchronous active-low reset (clears pointers, count, full)
//   push_i   write din_i at the tail
//   pop_i    remove the head entry (ignored when empty)
//   din_i    ID to enqueue
//   head_o   ID at the head of the queue
//   count_o  number of valid entries (0..QDEPTH)
//   full_o   registered: count equals QDEPTH
//   drop_o   push_i was discarded this cycle
module fpu_out_arb_q
  import fpu_out_arb_pkg::*;
#(
  parameter int ID_W   = ID_W_DEF,
  parameter int QDEPTH = QDEPTH_DEF
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      push_i,
  input  logic                      pop_i,
  input  logic [ID_W-1:0]           din_i,
  output logic [ID_W-1:0]           head_o,
  output logic [$clog2(QDEPTH):0]   count_o,
  output logic                      full_o,
  output logic                      drop_o
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ID_W-1:0]  mem_q [QDEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             do_push, do_pop;

  // A full queue still accepts a push when the head leaves in the same
  // cycle, so a steady push/pop stream never loses entries.
  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && (!full_q || do_pop);
  assign drop_o  = push_i && full_q && !do_pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d = (count_d == CNT_W'(QDEPTH));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
    end
  end

  // Storage needs no reset: entries are only visible through count_q.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = full_q;

endmodule

// File: rtl/fpu_out_arb.sv
// fpu_out_arb
//   FPU output arbiter. Collects result IDs from NPIPE execution pipes,
//   buffers each pipe in a small queue, and issues one registered request
//   per cycle towards the CPX. Pipe NPIPE-1 (divide) has strict priority;
//   pipes 0..NPIPE-2 share the remaining slots round-robin. A request that
//   arrives at an empty queue and wins goes straight to the output register
//   (one-cycle latency). While the CPX stalls a valid request, the output
//   holds and arriving results are queued. Requires NPIPE >= 2.
//
// Configuration macro
//   FPU_OUT_ARB_STARVE_EN  when defined, each round-robin pipe keeps a
//                          starvation counter; a pipe whose counter reaches
//                          STARVE_MAX outranks the priority pipe.
//
// Ports
//   rclk           clock
//   arst_l         asynchronous active-low reset
//   pipe_req_in    per-pipe result valid
//   pipe_id_in     per-pipe result ID, pipe p at [p*ID_W +: ID_W]
//   cpx_stall      CPX cannot accept the current request this cycle
//   pipe_full      registered per-pipe queue-full flags
//   req_vld        output request valid
//   fp_cpx_req_cq  CPX request field of the current request (ID[ID_W-1:2])
//   req_thread     thread of the current request (ID[1:0])
//   dest_rdy       one-hot pipe that supplied the current request
//   ovf_err        sticky: a result was dropped at a full queue
module fpu_out_arb
  import fpu_out_arb_pkg::*;
#(
  parameter int NPIPE      = NPIPE_DEF,
  parameter int ID_W       = ID_W_DEF,
  parameter int QDEPTH     = QDEPTH_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                    rclk,
  input  logic                    arst_l,
  input  logic [NPIPE-1:0]        pipe_req_in,
  input  logic [NPIPE*ID_W-1:0]   pipe_id_in,
  input  logic                    cpx_stall,
  output logic [NPIPE-1:0]        pipe_full,
  output logic                    req_vld,
  output logic [ID_W-THR_W-1:0]   fp_cpx_req_cq,
  output logic [THR_W-1:0]        req_thread,
  output logic [NPIPE-1:0]        dest_rdy,
  output logic                    ovf_err
);

  localparam int NRR   = NPIPE - 1;
  localparam int RR_W  = (NRR > 1) ? $clog2(NRR) : 1;
  localparam int CNT_W = $clog2(QDEPTH) + 1;

  // Per-pipe queue interface
  logic [ID_W-1:0]  q_head [NPIPE];
  logic [CNT_W-1:0] q_cnt  [NPIPE];
  logic [NPIPE-1:0] q_push, q_pop, q_drop, q_nonempty;

  // Arbitration
  logic [NPIPE-1:0] cand_vld;
  logic [ID_W-1:0]  cand_id [NPIPE];
  logic [NPIPE-1:0] gnt;
  logic             win_vld;
  int unsigned      win_idx;
  logic [ID_W-1:0]  win_id;
  logic             load;

  // State
  logic [RR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic             req_vld_q, req_vld_d;
  logic [NPIPE-1:0] dest_q, dest_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic             ovf_q, ovf_d;

  for (genvar g = 0; g < NPIPE; g++) begin : g_q
    fpu_out_arb_q #(
      .ID_W   (ID_W),
      .QDEPTH (QDEPTH)
    ) u_q (
      .clk_i   (rclk),
      .rst_ni  (arst_l),
      .push_i  (q_push[g]),
      .pop_i   (q_pop[g]),
      .din_i   (pipe_id_in[g*ID_W +: ID_W]),
      .head_o  (q_head[g]),
      .count_o (q_cnt[g]),
      .full_o  (pipe_full[g]),
      .drop_o  (q_drop[g])
    );
  end

  // Queued results are older than the incoming one, so the head is the
  // candidate whenever the queue is non-empty; otherwise the live input.
  always_comb begin
    for (int p = 0; p < NPIPE; p++) begin
      q_nonempty[p] = (q_cnt[p] != '0);
      cand_vld[p]   = q_nonempty[p] || pipe_req_in[p];
      cand_id[p]    = q_nonempty[p] ? q_head[p] : pipe_id_in[p*ID_W +: ID_W];
    end
  end

  // The output slot frees up when it is empty or the CPX takes it now.
  assign load = !req_vld_q || !cpx_stall;

`ifdef FPU_OUT_ARB_STARVE_EN
  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  logic [SW-1:0] starve_q [NRR];
  logic [SW-1:0] starve_d [NRR];

  // Count cycles a round-robin pipe waited while the priority pipe was
  // served; reset the count once the pipe itself is served.
  always_comb begin
    for (int i = 0; i < NRR; i++) begin
      starve_d[i] = starve_q[i];
      if (load && gnt[i]) begin
        starve_d[i] = '0;
      end else if (load && gnt[NPIPE-1] && cand_vld[i] &&
                   (starve_q[i] != SW'(STARVE_MAX))) begin
        starve_d[i] = starve_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      for (int i = 0; i < NRR; i++) starve_q[i] <= '0;
    end else begin
      for (int i = 0; i < NRR; i++) starve_q[i] <= starve_d[i];
    end
  end
`endif

  // Grant: starved pipes (if enabled), then the priority pipe, then a
  // round-robin scan starting at rr_ptr.
  always_comb begin
    logic found;
    int   idx;
    found = 1'b0;
    idx   = 0;
    gnt   = '0;
`ifdef FPU_OUT_ARB_STARVE_EN
    for (int i = 0; i < NRR; i++) begin
      if (!found && cand_vld[i] && (starve_q[i] == SW'(STARVE_MAX))) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
`endif
    if (!found && cand_vld[NPIPE-1]) begin
      gnt[NPIPE-1] = 1'b1;
      found        = 1'b1;
    end
    for (int k = 0; k < NRR; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NRR) idx = idx - NRR;
      for (int p = 0; p < NRR; p++) begin
        if (!found && (p == idx) && cand_vld[p]) begin
          gnt[p] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

  assign win_vld = |gnt;
  assign win_idx = oh_to_idx(32'(gnt));

  always_comb begin
    win_id = '0;
    for (int p = 0; p < NPIPE; p++) begin
      if (gnt[p]) win_id = cand_id[p];
    end
  end

  // A winner with an empty queue consumes its live input, which is then
  // not enqueued; every other arriving result is pushed.
  always_comb begin
    for (int p = 0; p < NPIPE; p++) begin
      q_pop[p]  = load && gnt[p] && q_nonempty[p];
      q_push[p] = pipe_req_in[p] && !(load && gnt[p] && !q_nonempty[p]);
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (load && win_vld && (win_idx < unsigned'(NRR))) begin
      rr_ptr_d = (win_idx + 1 >= unsigned'(NRR)) ? '0 : RR_W'(win_idx + 1);
    end
  end

  // With nothing to send the valid and one-hot drop, but the ID fields
  // keep their last value.
  always_comb begin
    req_vld_d = req_vld_q;
    dest_d    = dest_q;
    id_d      = id_q;
    if (load) begin
      req_vld_d = win_vld;
      dest_d    = gnt;
      if (win_vld) id_d = win_id;
    end
  end

  assign ovf_d = ovf_q || (|q_drop);

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      rr_ptr_q  <= '0;
      req_vld_q <= 1'b0;
      dest_q    <= '0;
      id_q      <= '0;
      ovf_q     <= 1'b0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      req_vld_q <= req_vld_d;
      dest_q    <= dest_d;
      id_q      <= id_d;
      ovf_q     <= ovf_d;
    end
  end

  assign req_vld       = req_vld_q;
  assign dest_rdy      = dest_q;
  assign fp_cpx_req_cq = id_q[ID_W-1:THR_W];
  assign req_thread    = id_q[THR_W-1:0];
  assign ovf_err       = ovf_q;

endmodule
